// File: rtl/edge_pipe_sched.sv
// rtl/edge_pipe_sched.sv - raster-locked scheduler for the input FIFO -> edge_detect -> output FIFO path
// Issues all FIFO requests and the kernel enable, commits mode at frame start, flushes between frames.
module edge_pipe_sched #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PREFILL    = 642,
  parameter int KERNEL_LAT = 2,
  parameter int FLUSH_MAX  = 2047
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        pix_valid,
  input  logic        vga_vs,
  input  logic [2:0]  mode_sw,
  input  logic        clr_err,
  input  logic [10:0] in_usedw,
  input  logic        in_full,
  input  logic        in_empty,
  input  logic        out_empty,
  output logic        in_wrreq,
  output logic        in_rdreq,
  output logic        out_wrreq,
  output logic        out_rdreq,
  output logic        kern_en,
  output logic [2:0]  mode,
  output logic        edge_sel,
  output logic [9:0]  col,
  output logic [8:0]  row,
  output logic        ovf_err,
  output logic        udf_err,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BYPASS  = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_PREFILL = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] MODE_EDGE = 3'b110;

  localparam int DLY_W = KERNEL_LAT + 1;
  localparam int FC_W  = $clog2(FLUSH_MAX + 1);
  localparam logic [FC_W-1:0] FLUSH_LAST  = FC_W'(FLUSH_MAX - 1);
  localparam logic [10:0]     PREFILL_LVL = 11'(PREFILL);
  localparam logic [9:0]      H_LAST      = 10'(H_ACTIVE - 1);
  localparam logic [8:0]      V_LAST      = 9'(V_ACTIVE - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       mode_q, mode_d;
  logic             vs_q, vs_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [9:0]       col_q, col_d;
  logic [8:0]       row_q, row_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             kern_en_q, kern_en_d, edge_sel_q, edge_sel_d;
  logic             frame_start, edge_mode, wr_want, flush_entry, streaming;

  assign frame_start = vs_q & ~vga_vs;
  assign edge_mode   = (sync2_q == MODE_EDGE);
  assign streaming   = (state_q == S_PREFILL) || (state_q == S_RUN);
  assign flush_entry = (state_d == S_FLUSH) && (state_q != S_FLUSH);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      mode_q      <= '0;
      vs_q        <= 1'b0;
      flush_cnt_q <= '0;
      dly_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      kern_en_q   <= 1'b0;
      edge_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      mode_q      <= mode_d;
      vs_q        <= vs_d;
      flush_cnt_q <= flush_cnt_d;
      dly_q       <= dly_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      kern_en_q   <= kern_en_d;
      edge_sel_q  <= edge_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = edge_mode ? S_FLUSH : S_BYPASS;
      S_BYPASS: if (frame_start && edge_mode) state_d = S_FLUSH;
      // A new frame while flushing keeps flushing; the counter restarts below.
      S_FLUSH: begin
        if (!frame_start && ((in_empty && out_empty) || flush_cnt_q == FLUSH_LAST))
          state_d = S_PREFILL;
      end
      S_PREFILL, S_RUN: begin
        if (frame_start)
          state_d = edge_mode ? S_FLUSH : S_BYPASS;
        else if (state_q == S_PREFILL && in_usedw >= PREFILL_LVL)
          state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_want    = streaming & pix_valid;
    in_wrreq   = wr_want & ~in_full;
    in_rdreq   = 1'b0;
    out_rdreq  = 1'b0;
    case (state_q)
      S_FLUSH: begin
        in_rdreq  = ~in_empty;
        out_rdreq = ~out_empty;
      end
      S_RUN: begin
        in_rdreq  = pix_valid & ~in_empty;
        out_rdreq = pix_valid & ~out_empty;
      end
      default: ;
    endcase
    kern_en_d  = (state_d == S_RUN);
    edge_sel_d = (state_d == S_RUN);
  end

  always_comb begin
    sync1_d = mode_sw;
    sync2_d = sync1_q;
    vs_d    = vga_vs;
    mode_d  = frame_start ? sync2_q : mode_q;

    flush_cnt_d = '0;
    if (state_q == S_FLUSH && state_d == S_FLUSH && !frame_start)
      flush_cnt_d = flush_cnt_q + 1'b1;

    // Only RUN reads carry pixels into the kernel; flush reads are discarded.
    dly_d = {dly_q[DLY_W-2:0], in_rdreq & (state_q == S_RUN)};
    if (frame_start && streaming)
      dly_d = '0;

    col_d = col_q;
    row_d = row_q;
    if (out_wrreq) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? 9'd0 : row_q + 9'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    if (flush_entry) begin
      col_d = '0;
      row_d = '0;
    end

    ovf_d = (wr_want & in_full) | (ovf_q & ~clr_err);
    udf_d = ((state_q == S_RUN) & pix_valid & (in_empty | out_empty)) | (udf_q & ~clr_err);
  end

  assign out_wrreq = dly_q[DLY_W-1];
  assign kern_en   = kern_en_q;
  assign edge_sel  = edge_sel_q;
  assign mode      = mode_q;
  assign col       = col_q;
  assign row       = row_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_edge_pipe_sched.sv
// tb/tb_edge_pipe_sched.sv - randomized self-checking bench for edge_pipe_sched
// Reference model tracks raster position and pending kernel writes as cycle stamps.
module tb_edge_pipe_sched;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        pix_valid = 1'b0, vga_vs = 1'b1, clr_err = 1'b0;
  logic [2:0]  mode_sw = 3'd0;
  logic [10:0] in_usedw = 11'd0;
  logic        in_full = 1'b0, in_empty = 1'b1, out_empty = 1'b1;
  logic        in_wrreq, in_rdreq, out_wrreq, out_rdreq, kern_en, edge_sel, ovf_err, udf_err;
  logic [2:0]  mode, state;
  logic [9:0]  col;
  logic [8:0]  row;

  always #5 clk = ~clk;

  edge_pipe_sched dut (
    .clk(clk), .RESET_N(RESET_N), .pix_valid(pix_valid), .vga_vs(vga_vs),
    .mode_sw(mode_sw), .clr_err(clr_err), .in_usedw(in_usedw), .in_full(in_full),
    .in_empty(in_empty), .out_empty(out_empty), .in_wrreq(in_wrreq), .in_rdreq(in_rdreq),
    .out_wrreq(out_wrreq), .out_rdreq(out_rdreq), .kern_en(kern_en), .mode(mode),
    .edge_sel(edge_sel), .col(col), .row(row), .ovf_err(ovf_err), .udf_err(udf_err),
    .state(state)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 bypass, 2 flush, 3 prefill, 4 run
  int m_state, m_mode, m_sw_d1, m_sw_d2, m_flush_n, m_pix, m_cyc;
  bit m_vs_prev, m_ovf, m_udf;
  int m_rd_cyc[$];

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_sw_d1 = 0; m_sw_d2 = 0; m_flush_n = 0;
    m_pix = 0; m_cyc = 0; m_vs_prev = 0; m_ovf = 0; m_udf = 0;
    m_rd_cyc.delete();
  endtask

  function automatic bit wr_due();
    return m_rd_cyc.size() > 0 && m_rd_cyc[0] == m_cyc - 3;
  endfunction

  task automatic compare_all();
    bit run, pre, fl;
    run = (m_state == 4);
    pre = (m_state == 3);
    fl  = (m_state == 2);
    check("state", state, m_state);
    check("in_wrreq", in_wrreq, (run || pre) && pix_valid && !in_full);
    check("in_rdreq", in_rdreq, fl ? !in_empty : (run && pix_valid && !in_empty));
    check("out_rdreq", out_rdreq, fl ? !out_empty : (run && pix_valid && !out_empty));
    check("out_wrreq", out_wrreq, wr_due());
    check("kern_en", kern_en, run);
    check("edge_sel", edge_sel, run);
    check("mode", mode, m_mode);
    check("col", col, m_pix % 640);
    check("row", row, (m_pix / 640) % 480);
    check("ovf_err", ovf_err, m_ovf);
    check("udf_err", udf_err, m_udf);
  endtask

  task automatic model_tick();
    bit fs, run, pre, rd_issue;
    int synced, nxt;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    fs = m_vs_prev && !vga_vs;
    synced = m_sw_d2;
    run = (m_state == 4);
    pre = (m_state == 3);
    rd_issue = run && pix_valid && !in_empty;
    m_ovf = ((run || pre) && pix_valid && in_full) || (m_ovf && !clr_err);
    m_udf = (run && pix_valid && (in_empty || out_empty)) || (m_udf && !clr_err);
    if (wr_due()) begin
      m_pix = (m_pix + 1) % (640 * 480);
      void'(m_rd_cyc.pop_front());
    end
    if (fs && (run || pre)) m_rd_cyc.delete();
    else if (rd_issue) m_rd_cyc.push_back(m_cyc);
    nxt = m_state;
    case (m_state)
      0: if (fs) nxt = (synced == 6) ? 2 : 1;
      1: if (fs && synced == 6) nxt = 2;
      2: begin
        if (fs) m_flush_n = 0;
        else begin
          m_flush_n++;
          if ((in_empty && out_empty) || m_flush_n == 2047) nxt = 3;
        end
      end
      3, 4: begin
        if (fs) nxt = (synced == 6) ? 2 : 1;
        else if (m_state == 3 && in_usedw >= 642) nxt = 4;
      end
      default: nxt = 0;
    endcase
    if (nxt == 2 && m_state != 2) begin
      m_flush_n = 0;
      m_pix = 0;
    end
    if (fs) m_mode = synced;
    m_state = nxt;
    m_sw_d2 = m_sw_d1;
    m_sw_d1 = mode_sw;
    m_vs_prev = vga_vs;
    m_cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic frame_pulse();
    vga_vs = 1'b0;
    cycle();
    vga_vs = 1'b1;
  endtask

  task automatic rand_flags();
    pix_valid = 1'($urandom % 2);
    in_full   = ($urandom % 10) == 0;
    in_empty  = ($urandom % 6) == 0;
    out_empty = ($urandom % 6) == 0;
    clr_err   = ($urandom % 25) == 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    repeat (3) cycle();
    check("rst_state", state, 0);
    check("rst_mode", mode, 0);
    check("rst_kern_en", kern_en, 0);

    // First edge frame: FIFOs already empty so flush lasts one cycle
    mode_sw = 3'b110;
    RESET_N = 1'b1;
    repeat (4) cycle();
    frame_pulse();
    check("fs_to_flush", state, 2);
    check("fs_mode_commit", mode, 6);
    n = 0;
    while (state == 3'd2 && n < 10) begin cycle(); n++; end
    check("flush_empty_len", n, 1);
    repeat (20) begin
      rand_flags();
      in_usedw = 11'($urandom_range(0, 641));
      cycle();
    end
    check("prefill_hold", state, 3);
    in_usedw = 11'd642;
    cycle();
    check("prefill_to_run", state, 4);
    check("run_kern_en", kern_en, 1);

    // One full line of pixels advances the raster to (0,1)
    pix_valid = 1'b1; in_empty = 1'b0; out_empty = 1'b0; in_full = 1'b0; clr_err = 1'b0;
    repeat (640) cycle();
    pix_valid = 1'b0;
    repeat (4) cycle();
    check("line_col", col, 0);
    check("line_row", row, 1);

    pix_valid = 1'b1;
    cycle();
    pix_valid = 1'b0;
    n = 1;
    while (out_wrreq !== 1'b1 && n < 10) begin cycle(); n++; end
    check("rd_to_wr_lat", n, 3);

    repeat (300) begin
      rand_flags();
      in_usedw = 11'($urandom_range(500, 800));
      cycle();
    end

    // Mode change mid-frame is held until frame start
    mode_sw = 3'b001;
    repeat (10) begin rand_flags(); cycle(); end
    check("mode_held", mode, 6);
    check("still_run", state, 4);
    frame_pulse();
    check("bypass_state", state, 1);
    check("bypass_edge_sel", edge_sel, 0);
    check("bypass_mode", mode, 1);
    repeat (20) begin rand_flags(); cycle(); end

    // Overflow flag: set, clear, and set winning over clear
    mode_sw = 3'b110;
    pix_valid = 1'b0; in_full = 1'b0; in_empty = 1'b1; out_empty = 1'b1; clr_err = 1'b0;
    in_usedw = 11'd0;
    repeat (3) cycle();
    frame_pulse();
    cycle();
    check("prefill_again", state, 3);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    pix_valid = 1'b1; in_full = 1'b1;
    #1;
    check("ovf_wrreq_dropped", in_wrreq, 0);
    cycle();
    check("ovf_set", ovf_err, 1);
    pix_valid = 1'b0; in_full = 1'b0; clr_err = 1'b1;
    cycle();
    check("ovf_cleared", ovf_err, 0);
    pix_valid = 1'b1; in_full = 1'b1;
    cycle();
    check("ovf_set_wins", ovf_err, 1);
    pix_valid = 1'b0; in_full = 1'b0;
    cycle();
    clr_err = 1'b0;

    // Flush with output FIFO never draining hits the cycle limit
    out_empty = 1'b0;
    frame_pulse();
    n = 0;
    while (state == 3'd2 && n < 3000) begin
      in_empty = 1'($urandom % 2);
      cycle();
      n++;
    end
    check("flush_max_len", n, 2047);
    check("flush_max_exit", state, 3);

    // Reset in the middle of RUN
    in_usedw = 11'd642; out_empty = 1'b1; in_empty = 1'b0;
    cycle();
    check("run_before_rst", state, 4);
    repeat (10) begin rand_flags(); cycle(); end
    pix_valid = 1'b1; in_empty = 1'b0; out_empty = 1'b0; in_full = 1'b0;
    RESET_N = 1'b0;
    model_reset();
    #2;
    check("async_rst_state", state, 0);
    check("async_rst_rdreq", in_rdreq, 0);
    check("async_rst_wrreq", in_wrreq, 0);
    cycle();
    RESET_N = 1'b1;
    repeat (20) begin rand_flags(); cycle(); end
    check("post_rst_idle", state, 0);

    // Free-running soak with random frames and modes
    repeat (4000) begin
      rand_flags();
      in_usedw = 11'($urandom_range(560, 700));
      if ($urandom % 40 == 0) mode_sw = ($urandom % 2) ? 3'b110 : 3'($urandom);
      vga_vs = ($urandom % 150) != 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
